// File: rtl/wb_chkpt_pkg.sv
// Shared definitions for the checkpoint port: register map, STATUS/CTRL
// bit positions, sequencer state encoding and the hold reload helper.
package wb_chkpt_pkg;

    // Register index taken from wbs_adr_i[3:2]
    localparam logic [1:0] REG_CODE   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_HOLD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions (COUNT occupies [4:0])
    localparam int unsigned STAT_EMPTY = 6;
    localparam int unsigned STAT_FULL  = 7;
    localparam int unsigned STAT_BUSY  = 8;
    localparam int unsigned STAT_OVF   = 9;

    // CTRL bit positions
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } chk_state_t;

    // Counter reload so a HOLD of 0 behaves like a HOLD of 1
    function automatic logic [15:0] hold_reload(input logic [15:0] hold);
        return (hold == 16'd0) ? 16'd0 : hold - 16'd1;
    endfunction

endpackage

// File: rtl/chkpt_sync_fifo.sv
// Synchronous 16-bit FIFO holding queued checkpoint codes.
// Flush has priority over push; a push while full is ignored.
module chkpt_sync_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        full,
    output logic        empty,
    output logic [4:0]  count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 5'(DEPTH));
    assign empty   = (count == 5'd0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_chkpt_port.sv
// Wishbone slave that queues 16-bit checkpoint codes and shows each one
// on chk_o for a programmable number of cycles.
module wb_chkpt_port
    import wb_chkpt_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] HOLD_RST = 16'd16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [15:0] chk_o,
    output logic [15:0] chk_oeb_o
);

    logic        access;
    logic        bus_wr;
    logic        bus_rd;
    logic [1:0]  reg_idx;
    logic        code_push;
    logic        flush;
    logic        ovf_clr;
    logic        en;
    logic        ovf;
    logic [15:0] hold_reg;
    logic [15:0] hold_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic [15:0] fifo_head;
    logic        fifo_pop;
    logic [31:0] status_word;
    logic [31:0] rdata;
    chk_state_t  state;
    chk_state_t  state_nx;
    logic        unused_bits;

    // Register access happens on the same edge that raises ack
    assign access    = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign bus_wr    = access && wbs_we_i;
    assign bus_rd    = access && !wbs_we_i;
    assign reg_idx   = wbs_adr_i[3:2];
    assign code_push = bus_wr && (reg_idx == REG_CODE) && (wbs_sel_i[1:0] == 2'b11);
    assign flush     = bus_wr && (reg_idx == REG_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_FLUSH];
    assign ovf_clr   = bus_wr && (reg_idx == REG_STATUS) && wbs_sel_i[1] && wbs_dat_i[STAT_OVF];
    assign chk_oeb_o = en ? '0 : '1;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

    chkpt_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .push  (code_push),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (wbs_dat_i[15:0]),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read mux, including STATUS assembly
    always_comb begin
        status_word             = '0;
        status_word[4:0]        = fifo_count;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_BUSY]  = (state != S_IDLE);
        status_word[STAT_OVF]   = ovf;
        case (reg_idx)
            REG_CODE:   rdata = {16'h0000, chk_o};
            REG_STATUS: rdata = status_word;
            REG_HOLD:   rdata = {16'h0000, hold_reg};
            default:    rdata = {31'h0, en};
        endcase
    end

    // Single-cycle ack and registered read data
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= bus_rd ? rdata : '0;
        end
    end

    // Control registers: HOLD and EN with byte enables, sticky OVF
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            en       <= 1'b0;
            hold_reg <= HOLD_RST;
            ovf      <= 1'b0;
        end else begin
            if (bus_wr && (reg_idx == REG_HOLD)) begin
                if (wbs_sel_i[0]) hold_reg[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) hold_reg[15:8] <= wbs_dat_i[15:8];
            end
            if (bus_wr && (reg_idx == REG_CTRL) && wbs_sel_i[0]) begin
                en <= wbs_dat_i[CTRL_EN];
            end
            if (code_push && fifo_full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sequencer next state; flush overrides everything and suppresses the pop
    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && !fifo_empty) state_nx = S_LOAD;
                end
                S_LOAD: begin
                    fifo_pop = 1'b1;
                    state_nx = S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt == 16'd0) begin
                        state_nx = (en && !fifo_empty) ? S_LOAD : S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Display register and hold counter
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            chk_o    <= '0;
            hold_cnt <= '0;
        end else if (fifo_pop) begin
            chk_o    <= fifo_head;
            hold_cnt <= hold_reload(hold_reg);
        end else if ((state == S_HOLD) && (hold_cnt != 16'd0)) begin
            hold_cnt <= hold_cnt - 16'd1;
        end
    end

endmodule
